pb_debounce_multi: RTL and testbench
====================================

Name: pb_debounce_multi

Overview:
- Parametrised multi-channel pushbutton conditioner: per-channel 2-FF synchroniser, counter-based stability filter, edge pulses and a long-press pulse.
- Replaces the fixed single-channel two-flop debouncer.
- Sits between raw board buttons/switches and the timer control FSM, which consumes the one-cycle pulses directly.

Parameters:
- N_CH, 4, number of independent input channels.
- CNT_W, 16, width of each stability counter; STABLE_CNT must be <= 2^CNT_W.
- STABLE_CNT, 50000, consecutive clk cycles the synchronised input must differ from db_level before db_level changes; legal range 1..2^CNT_W.
- HOLD_W, 24, width of each hold counter.
- HOLD_CNT, 10000000, cycles db_level must stay 1 before hold_pulse fires; legal range 1..2^HOLD_W.
- ACTIVE_LOW, 0, 1 = raw pb inputs are inverted before synchronisation so that internal level 1 always means "pressed".

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pb  in  N_CH  raw asynchronous button inputs.
- db_level  out  N_CH  debounced level per channel (1 = pressed).
- rise  out  N_CH  one-cycle pulse when db_level goes 0->1.
- fall  out  N_CH  one-cycle pulse when db_level goes 1->0.
- hold_pulse  out  N_CH  one-cycle pulse once per press after HOLD_CNT cycles held.

Behaviour:
- Reset (async, active-high): sync FFs, db_level, rise, fall, hold_pulse, all counters -> 0. Takes effect immediately mid-count and mid-pulse; outputs stay 0 while reset is high.
- Polarity: s_in[i] = pb[i] XOR ACTIVE_LOW. Sync chain: ff1 <= s_in, ff2 <= ff1. Only ff2 (sync) feeds the filter.
- Stability filter, per channel, on every clk edge:
  - If sync == db_level: cnt <= 0.
  - Else if cnt == STABLE_CNT-1: db_level <= sync; cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: if pb is first sampled by ff1 at edge 0 and stays stable, db_level changes at edge STABLE_CNT+1. With STABLE_CNT=1 this is edge 2.
- Glitch rejection: any single cycle with sync == db_level clears cnt, so a bounce restarts the full window.
- Edge pulses: rise/fall are registered and assert in the same cycle db_level takes its new value, for exactly one cycle. rise and fall are never both high on one channel.
- Hold logic, per channel:
  - While db_level == 1 and the hold flag is clear: hcnt increments.
  - When hcnt == HOLD_CNT-1: hold_pulse <= 1 for one cycle; hold flag set; hcnt <= 0.
  - While db_level == 0: hcnt <= 0 and hold flag cleared.
  - Exactly one hold_pulse per press regardless of press length.
  - First held cycle counts from the cycle after rise; hold_pulse fires HOLD_CNT cycles after rise asserts.
- Counters never wrap: cnt is bounded by STABLE_CNT-1 and hcnt by HOLD_CNT-1.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses with no arbitration.
- pb changing while reset is high has no effect until reset deasserts; channels then start from db_level = 0.

Test Plan:
- N_CH=4, STABLE_CNT=4, HOLD_CNT=10, ACTIVE_LOW=0. Hold reset 3 cycles with pb=4'hF -> all outputs 0 during reset. pb[0] then held 1 -> db_level[0]=1 and rise[0]=1 (one cycle) exactly at edge 5 after ff1 first samples it.
- Bounce on pb[1]: 1 for 3 cycles, 0 for 1, then 1 steady -> no rise during bounce. rise[1] occurs 5 edges after the final 0->1 sample; exactly one pulse.
- Release after steady press on pb[0]: pb[0]=0 steady -> fall[0] one cycle at STABLE_CNT+1 edges; db_level[0]=0; no hold_pulse if press lasted <10 cycles after rise.
- Long press on pb[2] for 40 cycles after rise -> exactly one hold_pulse[2], 10 cycles after rise[2]. A second press re-arms and gives one more hold_pulse.
- Simultaneous press on pb[3:0]=4'hF from idle -> rise=4'hF in the same cycle. Assert reset mid-window (cnt=2) -> db_level stays 0, counters cleared; after release, a full 4-cycle window is required again.
- ACTIVE_LOW=1, STABLE_CNT=1: out of reset with pb=4'hF -> db_level stays 0. pb[0] driven 0 -> db_level[0]=1 and rise[0] at edge 2.

Source files
------------

// File: rtl/pb_debounce_multi.sv
// rtl/pb_debounce_multi.sv - multi-channel pushbutton synchroniser, debouncer, edge and long-press pulses
// Each channel is independent: 2-FF sync, stability counter, registered rise/fall and one hold pulse per press.
module pb_debounce_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000,
  parameter int HOLD_W     = 24,
  parameter int HOLD_CNT   = 10000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hold_pulse
);

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CNT - 1);

  logic [N_CH-1:0] s_in;
  logic [N_CH-1:0] ff1;
  logic [N_CH-1:0] sync;

  assign s_in = pb ^ {N_CH{ACTIVE_LOW}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1  <= '0;
      sync <= '0;
    end else begin
      ff1  <= s_in;
      sync <= ff1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hcnt;
    logic              held;
    logic              db_r;
    logic              rise_r;
    logic              fall_r;
    logic              hold_r;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        hcnt   <= '0;
        held   <= 1'b0;
        db_r   <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        hold_r <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        hold_r <= 1'b0;

        // Any cycle agreeing with the current level restarts the whole window.
        if (sync[i] == db_r) begin
          cnt <= '0;
        end else if (cnt == STABLE_LAST) begin
          db_r   <= sync[i];
          cnt    <= '0;
          rise_r <= sync[i];
          fall_r <= ~sync[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        // held latches after the pulse so a long press yields only one.
        if (!db_r) begin
          hcnt <= '0;
          held <= 1'b0;
        end else if (!held) begin
          if (hcnt == HOLD_LAST) begin
            hold_r <= 1'b1;
            held   <= 1'b1;
            hcnt   <= '0;
          end else begin
            hcnt <= hcnt + HOLD_W'(1);
          end
        end
      end
    end

    assign db_level[i]   = db_r;
    assign rise[i]       = rise_r;
    assign fall[i]       = fall_r;
    assign hold_pulse[i] = hold_r;
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb/tb_pb_debounce_multi.sv - self-checking bench for pb_debounce_multi
// Table vectors on an active-low instance, directed and random checks on an active-high instance.
module tb_pb_debounce_multi;

  localparam int S_A = 4;
  localparam int H_A = 10;

  logic       clk;
  logic       reset_a, reset_b;
  logic [3:0] pb_a, pb_b;
  logic [3:0] a_db, a_rise, a_fall, a_hold;
  logic [3:0] b_db, b_rise, b_fall, b_hold;

  int n_chk;
  int n_fail;

  pb_debounce_multi #(.N_CH(4), .CNT_W(4), .STABLE_CNT(S_A), .HOLD_W(8), .HOLD_CNT(H_A), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .reset(reset_a), .pb(pb_a),
    .db_level(a_db), .rise(a_rise), .fall(a_fall), .hold_pulse(a_hold)
  );

  pb_debounce_multi #(.N_CH(4), .CNT_W(4), .STABLE_CNT(1), .HOLD_W(8), .HOLD_CNT(3), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset(reset_b), .pb(pb_b),
    .db_level(b_db), .rise(b_rise), .fall(b_fall), .hold_pulse(b_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Reference model for u_a: edge-indexed sample history since reset.
  logic [3:0] s_hist[$];
  logic [3:0] y_hist[$];
  logic [3:0] m_db, m_rise, m_fall, m_hold;
  int         rise_edge[4];
  int         m_n;

  task automatic model_clear();
    s_hist.delete();
    y_hist.delete();
    m_db = 0; m_rise = 0; m_fall = 0; m_hold = 0;
    m_n = 0;
    for (int i = 0; i < 4; i++) rise_edge[i] = -1000;
  endtask

  task automatic model_edge();
    logic [3:0] sync_now;
    logic       all_diff;
    int         sz;
    if (reset_a) begin
      model_clear();
      return;
    end
    // The filter sees the input sampled two edges earlier.
    sync_now = (s_hist.size() >= 2) ? s_hist[s_hist.size()-2] : 4'h0;
    s_hist.push_back(pb_a);
    y_hist.push_back(sync_now);
    m_rise = 0; m_fall = 0; m_hold = 0;
    for (int i = 0; i < 4; i++)
      if (m_db[i] && m_n == rise_edge[i] + H_A) m_hold[i] = 1'b1;
    sz = y_hist.size();
    for (int i = 0; i < 4; i++) begin
      all_diff = (sz >= S_A);
      if (sz >= S_A)
        for (int j = sz - S_A; j < sz; j++)
          if (y_hist[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[i] = ~m_db[i];
        if (m_db[i]) begin
          m_rise[i]    = 1'b1;
          rise_edge[i] = m_n;
        end else begin
          m_fall[i] = 1'b1;
        end
      end
    end
    while (s_hist.size() > 8) void'(s_hist.pop_front());
    while (y_hist.size() > 8) void'(y_hist.pop_front());
    m_n++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_a", {a_db, a_rise, a_fall, a_hold}, {m_db, m_rise, m_fall, m_hold});
  endtask

  task automatic set_reset_a(input logic v);
    reset_a = v;
    if (v) model_clear();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] pb;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl[28];

  initial begin
    int cnt;
    int pos;
    logic seen;
    logic found;

    n_chk = 0;
    n_fail = 0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    pb_a = 4'h0;
    pb_b = 4'hF;
    model_clear();

    // Active-low, single-cycle window, HOLD_CNT=3; expected outputs after each edge.
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[8]  = '{1'b0, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{1'b0, 4'hE, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[11] = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[14] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[16] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[17] = '{1'b0, 4'hF, 4'h2, 4'h2, 4'h0, 4'h0};
    tbl[18] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0};
    tbl[19] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[20] = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[21] = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[22] = '{1'b0, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[23] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[24] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[25] = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[26] = '{1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[27] = '{1'b0, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0};

    @(negedge clk);
    for (int k = 0; k < 28; k++) begin
      reset_b = tbl[k].rst;
      pb_b    = tbl[k].pb;
      step();
      chk($sformatf("tbl_b[%0d]", k), {b_db, b_rise, b_fall, b_hold},
          {tbl[k].db, tbl[k].rise, tbl[k].fall, tbl[k].hold});
    end

    // Reset held with all buttons pressed.
    pb_a = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_outputs", {a_db, a_rise, a_fall, a_hold}, 16'h0);
    end

    // First press: level and rise at edge 5 after first sample.
    set_reset_a(1'b0);
    pb_a = 4'h1;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 4) chk("press_before", {12'h0, a_db}, 16'h0);
      if (k == 5) chk("press_edge5", {8'h0, a_db, a_rise}, 16'h0011);
    end
    step();
    chk("rise_one_cycle", {12'h0, a_rise}, 16'h0);

    // Short press release: fall after full window, no hold pulse.
    pb_a = 4'h0;
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 6) chk("release_fall", {8'h0, a_db, a_fall}, 16'h0001);
      seen = seen | a_hold[0];
    end
    chk("short_no_hold", {15'h0, seen}, 16'h0);

    // Bounce on channel 1.
    seen = 1'b0;
    pb_a = 4'h2;
    for (int k = 0; k < 3; k++) begin step(); seen = seen | a_rise[1]; end
    pb_a = 4'h0;
    step(); seen = seen | a_rise[1];
    pb_a = 4'h2;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) seen = seen | a_rise[1];
      if (k == 5) chk("bounce_rise", {12'h0, a_rise}, 16'h0002);
    end
    chk("bounce_no_early_rise", {15'h0, seen}, 16'h0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin step(); if (a_rise[1]) cnt++; end
    chk("bounce_single_rise", 16'(cnt), 16'd0);
    pb_a = 4'h0;
    for (int k = 0; k < 20; k++) step();

    // Long press, then a second press re-arming the hold pulse.
    for (int p = 0; p < 2; p++) begin
      pb_a = 4'h4;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        step();
        if (a_rise[2]) found = 1'b1;
      end
      chk("long_rise_found", {15'h0, found}, 16'h1);
      cnt = 0;
      pos = 0;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (a_hold[2]) begin cnt++; pos = k; end
      end
      chk("hold_count", 16'(cnt), 16'd1);
      chk("hold_position", 16'(pos), 16'(H_A));
      pb_a = 4'h0;
      for (int k = 0; k < 20; k++) step();
    end

    // Simultaneous press on all channels.
    pb_a = 4'hF;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (a_rise != 4'h0) found = 1'b1;
    end
    chk("simul_rise", {11'h0, found, a_rise}, 16'h001F);
    pb_a = 4'h0;
    for (int k = 0; k < 20; k++) step();

    // Reset mid-window, then a full window is needed again.
    pb_a = 4'h1;
    for (int k = 0; k < 4; k++) step();
    chk("midwin_level", {12'h0, a_db}, 16'h0);
    set_reset_a(1'b1);
    #1;
    chk("midwin_reset_async", {a_db, a_rise, a_fall, a_hold}, 16'h0);
    step();
    step();
    set_reset_a(1'b0);
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 4) chk("rewin_before", {12'h0, a_db}, 16'h0);
      if (k == 5) chk("rewin_edge5", {8'h0, a_db, a_rise}, 16'h0011);
    end
    set_reset_a(1'b1);
    #1;
    chk("midpulse_reset_async", {a_db, a_rise, a_fall, a_hold}, 16'h0);
    step();
    step();
    set_reset_a(1'b0);
    pb_a = 4'h0;

    // Random stimulus against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) pb_a[i] = ~pb_a[i];
      if (reset_a) begin
        if ($urandom_range(0, 1) == 0) set_reset_a(1'b0);
      end else if ($urandom_range(0, 299) == 0) begin
        set_reset_a(1'b1);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
